// File: rtl/video_stream_gen.sv
// Programmable de/hs/vs pixel-stream source: frames of configurable size,
// pixel spacing and blanking, filled with one of four test patterns.
module video_stream_gen #(
  parameter int PIXEL_WIDTH       = 12,
  parameter int SPARSE_OUTPUT_MAX = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   en,
  input  logic [15:0]            h_last,
  input  logic [15:0]            v_last,
  input  logic [3:0]             sparse,
  input  logic [15:0]            line_gap,
  input  logic [15:0]            frame_gap,
  input  logic [1:0]             pattern,
  input  logic [PIXEL_WIDTH-1:0] const_val,
  output logic [PIXEL_WIDTH-1:0] do_o,
  output logic                   de_o,
  output logic                   hs_o,
  output logic                   vs_o,
  output logic                   busy_o
);

  localparam int SW = (SPARSE_OUTPUT_MAX > 0) ? $clog2(SPARSE_OUTPUT_MAX + 1) : 1;

  typedef enum logic [1:0] {IDLE, PIXEL, LINE_GAP, FRAME_GAP} state_t;

  typedef struct packed {
    logic [15:0]            h_last;
    logic [15:0]            v_last;
    logic [15:0]            line_gap;
    logic [15:0]            frame_gap;
    logic [SW-1:0]          sparse;
    logic [1:0]             pattern;
    logic [PIXEL_WIDTH-1:0] const_val;
  } cfg_t;

  state_t                 state, state_nxt;
  cfg_t                   cfg;
  logic [15:0]            x, y, cnt_gap;
  logic [SW-1:0]          cnt_sparse, sparse_clamped;
  logic                   strobe, last_slot, line_end, frame_end, gap_last;
  logic [PIXEL_WIDTH-1:0] pix;

  // Out-of-range spacing requests saturate rather than alias.
  assign sparse_clamped = (32'(sparse) > SPARSE_OUTPUT_MAX) ? SW'(SPARSE_OUTPUT_MAX) : SW'(sparse);

  assign strobe    = (state == PIXEL) && (cnt_sparse == '0);
  assign last_slot = (state == PIXEL) && (cnt_sparse == cfg.sparse);
  assign line_end  = last_slot && (x == cfg.h_last);
  assign frame_end = line_end && (y == cfg.v_last);
  assign gap_last  = (cnt_gap == 16'd1);
  assign busy_o    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  // Zero-length gaps skip their state entirely.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:      if (en) state_nxt = PIXEL;
      PIXEL: begin
        if (frame_end)                             state_nxt = (cfg.frame_gap == '0) ? IDLE : FRAME_GAP;
        else if (line_end && cfg.line_gap != '0)   state_nxt = LINE_GAP;
      end
      LINE_GAP:  if (gap_last) state_nxt = PIXEL;
      FRAME_GAP: if (gap_last) state_nxt = IDLE;
      default:   state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg        <= '0;
      x          <= '0;
      y          <= '0;
      cnt_sparse <= '0;
      cnt_gap    <= '0;
    end else begin
      case (state)
        IDLE: if (en) begin
          cfg        <= '{h_last: h_last, v_last: v_last, line_gap: line_gap,
                          frame_gap: frame_gap, sparse: sparse_clamped,
                          pattern: pattern, const_val: const_val};
          x          <= '0;
          y          <= '0;
          cnt_sparse <= '0;
        end
        PIXEL: begin
          cnt_sparse <= last_slot ? '0 : SW'(cnt_sparse + 1'b1);
          if (frame_end) cnt_gap <= cfg.frame_gap;
          else if (line_end) begin
            if (cfg.line_gap == '0) begin
              x <= '0;
              y <= y + 16'd1;
            end else begin
              cnt_gap <= cfg.line_gap;
            end
          end else if (last_slot) x <= x + 16'd1;
        end
        LINE_GAP: begin
          cnt_gap <= cnt_gap - 16'd1;
          if (gap_last) begin
            x <= '0;
            y <= y + 16'd1;
          end
        end
        FRAME_GAP: cnt_gap <= cnt_gap - 16'd1;
        default: ;
      endcase
    end
  end

  always_comb begin
    pix = '0;
    case (cfg.pattern)
      2'd0:    pix = PIXEL_WIDTH'(x);
      2'd1:    pix = PIXEL_WIDTH'(y);
      2'd2:    pix = {PIXEL_WIDTH{x[3] ^ y[3]}};
      default: pix = cfg.const_val;
    endcase
  end

  // do_o only updates on issued pixels so it holds through blanking.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      de_o <= 1'b0;
      hs_o <= 1'b0;
      vs_o <= 1'b0;
      do_o <= '0;
    end else begin
      de_o <= strobe;
      hs_o <= strobe && (x == '0);
      vs_o <= strobe && (x == '0) && (y == '0);
      if (strobe) do_o <= pix;
    end
  end

endmodule
